// File: rtl/cfg_chain_loader.sv
// Configuration shift-chain loader: takes parallel words over valid/ready, shifts them
// LSB-first onto CHAINS chains, then issues a timed set pulse. Optional macro CFG_SHIFT_DIV_EN.
module cfg_chain_loader #(
  parameter int CHAINS     = 4,
  parameter int WORD       = 8,
  parameter int CHAIN_LEN  = 20,
  parameter int SET_CYCLES = 2,
  parameter int DIV        = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic                     i_abort,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic [CHAINS*WORD-1:0]   i_in_data,
  output logic                     o_cen_out,
  output logic [CHAINS-1:0]        o_shift_out,
  output logic                     o_set_out,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam int REM_W = $clog2(CHAIN_LEN + 1);
  localparam int WB_W  = $clog2(WORD + 1);
  localparam int SC_W  = $clog2(SET_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_SET   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  if (CHAINS < 1 || WORD < 1 || CHAIN_LEN < 1 || SET_CYCLES < 1 || DIV < 1) begin : g_bad_param
    $error("cfg_chain_loader: all parameters must be >= 1");
  end

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [REM_W-1:0]         r_rem;
  logic [WB_W-1:0]          r_wbits;
  logic [WB_W-1:0]          w_take;
  logic [SC_W-1:0]          r_set_cnt;
  logic [CHAINS*WORD-1:0]   r_sreg;
  logic [CHAINS*WORD-1:0]   w_in_shr;
  logic [CHAINS*WORD-1:0]   w_sreg_shr;
  logic [CHAINS-1:0]        w_in_lsb;
  logic [CHAINS-1:0]        w_sreg_lsb;
  logic                     w_cen_nxt;
  logic                     w_accept;

  logic                     r_cen;
  logic [CHAINS-1:0]        r_shift;
  logic                     r_ready;
  logic                     r_set;
  logic                     r_busy;
  logic                     r_done;

  assign w_accept = (r_state == S_LOAD) && i_in_valid;

  // Last word of a frame may be partial: only the bits still owed to the chain are shifted.
  always_comb begin
    if (int'(r_rem) < WORD) w_take = WB_W'(r_rem);
    else                    w_take = WB_W'(WORD);
  end

  always_comb begin
    w_in_lsb   = '0;
    w_sreg_lsb = '0;
    w_in_shr   = '0;
    w_sreg_shr = '0;
    for (int c = 0; c < CHAINS; c++) begin
      w_in_lsb[c]                 = i_in_data[c*WORD];
      w_sreg_lsb[c]               = r_sreg[c*WORD];
      w_in_shr[c*WORD +: WORD]    = i_in_data[c*WORD +: WORD] >> 1;
      w_sreg_shr[c*WORD +: WORD]  = r_sreg[c*WORD +: WORD] >> 1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_LOAD;
      S_LOAD:  if (i_in_valid) w_state_nxt = S_SHIFT;
      S_SHIFT: begin
        if (r_cen && (r_wbits == WB_W'(1))) begin
          if (r_rem == REM_W'(1)) w_state_nxt = S_SET;
          else                    w_state_nxt = S_LOAD;
        end
      end
      S_SET:   if (r_set_cnt == '0) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    // Abort wins over everything; in IDLE it also suppresses a simultaneous start.
    if (i_abort) w_state_nxt = S_IDLE;
  end

`ifdef CFG_SHIFT_DIV_EN
  localparam int DV_W = $clog2(DIV + 1);
  logic [DV_W-1:0] r_div;
  logic [DV_W-1:0] w_div_nxt;

  // Down-counter reloads on SHIFT entry; a tick is the cycle where it reads zero.
  always_comb begin
    if (r_state != S_SHIFT)  w_div_nxt = DV_W'(DIV);
    else if (r_div == '0)    w_div_nxt = DV_W'(DIV - 1);
    else                     w_div_nxt = r_div - DV_W'(1);
    w_cen_nxt = (w_state_nxt == S_SHIFT) && (w_div_nxt == '0);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_div <= '0;
    else        r_div <= w_div_nxt;
  end
`else
  assign w_cen_nxt = (w_state_nxt == S_SHIFT);
`endif

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state   <= S_IDLE;
      r_cen     <= 1'b0;
      r_ready   <= 1'b0;
      r_set     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cen     <= w_cen_nxt;
      r_ready   <= (w_state_nxt == S_LOAD);
      r_set     <= (w_state_nxt == S_SET);
      r_busy    <= (w_state_nxt != S_IDLE);
      r_done    <= (w_state_nxt == S_DONE);
    end
  end

  // Outputs are registered from the next state, so the bit presented is loaded one edge early.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_shift <= '0;
      r_sreg  <= '0;
    end else if (w_cen_nxt) begin
      if (r_state == S_LOAD) begin
        r_shift <= w_in_lsb;
        r_sreg  <= w_in_shr;
      end else begin
        r_shift <= w_sreg_lsb;
        r_sreg  <= w_sreg_shr;
      end
    end else begin
      if (w_accept && (w_state_nxt == S_SHIFT)) r_sreg <= i_in_data;
      if (w_state_nxt != S_SHIFT) r_shift <= '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_rem     <= '0;
      r_wbits   <= '0;
      r_set_cnt <= '0;
    end else begin
      if ((r_state == S_IDLE) && (w_state_nxt == S_LOAD)) r_rem <= REM_W'(CHAIN_LEN);
      else if ((r_state == S_SHIFT) && r_cen)            r_rem <= r_rem - REM_W'(1);

      if (w_accept && (w_state_nxt == S_SHIFT))          r_wbits <= w_take;
      else if ((r_state == S_SHIFT) && r_cen)            r_wbits <= r_wbits - WB_W'(1);

      if (w_state_nxt == S_SET) begin
        if (r_state == S_SET) r_set_cnt <= r_set_cnt - SC_W'(1);
        else                  r_set_cnt <= SC_W'(SET_CYCLES - 1);
      end
    end
  end

  assign o_in_ready  = r_ready;
  assign o_cen_out   = r_cen;
  assign o_shift_out = r_shift;
  assign o_set_out   = r_set;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Directed bench for cfg_chain_loader with CHAINS=2, WORD=4, CHAIN_LEN=10, SET_CYCLES=2.
module tb_cfg_chain_loader;
  localparam logic [9:0] EXP0 = 10'b0111001010;
  localparam logic [9:0] EXP1 = 10'b0000110101;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort_i = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready, cen, set_out, busy, done;
  logic [1:0] shift_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cfg_chain_loader #(
    .CHAINS(2), .WORD(4), .CHAIN_LEN(10), .SET_CYCLES(2), .DIV(4)
  ) dut (
    .i_clk(clk), .i_rst(rst_n), .i_start(start), .i_abort(abort_i),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
    .o_cen_out(cen), .o_shift_out(shift_out), .o_set_out(set_out),
    .o_busy(busy), .o_done(done)
  );

  // Runs one frame of words 5A,3C,81 starting with a start pulse; collects observations.
  task automatic run_frame(input int bp_delay, input bit hold_valid, input int abort_kind,
                           input bit start_mid, output logic [9:0] s0, output logic [9:0] s1,
                           output int ncen, output int nset, output int ndone, output int nhs,
                           output int done_cyc, output int viol, output int nwait,
                           output logic [3:0] post_abort);
    logic [7:0] words [3];
    int wi, wcnt, cyc, after_abort;
    bit rdy, aborted;
    words[0] = 8'h5A; words[1] = 8'h3C; words[2] = 8'h81;
    s0 = '0; s1 = '0; ncen = 0; nset = 0; ndone = 0; nhs = 0; done_cyc = -1;
    viol = 0; nwait = 0; post_abort = '1;
    wi = 0; wcnt = 0; aborted = 0; after_abort = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (cyc < 60) begin
      if (aborted && after_abort == 0) post_abort = {busy, cen, in_ready, set_out};
      if (cen) begin
        if (ncen < 10) begin s0[ncen] = shift_out[0]; s1[ncen] = shift_out[1]; end
        ncen++;
      end else if (shift_out !== 2'b00) viol++;
      if (cen && in_ready) viol++;
      if (set_out) nset++;
      if (done) begin
        ndone++; done_cyc = cyc;
        if (busy !== 1'b1) viol++;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        if (busy !== 1'b0) viol++;
        break;
      end
      if (aborted) begin
        after_abort++;
        if (after_abort > 10) break;
      end
      abort_i = 1'b0;
      start = 1'b0;
      if (!aborted && ((abort_kind == 1 && cen && ncen == 3) ||
                       (abort_kind == 2 && set_out && nset == 1))) begin
        abort_i = 1'b1; aborted = 1;
      end
      if (start_mid && cen && ncen == 2) start = 1'b1;
      rdy = in_ready;
      if (wi < 3 && (hold_valid || (rdy && wcnt >= ((wi == 1) ? bp_delay : 0)))) begin
        in_valid = 1'b1; in_data = words[wi];
      end else begin
        in_valid = 1'b0;
        if (rdy) begin wcnt++; nwait++; end
      end
      @(posedge clk);
      if (in_valid && rdy) begin wi++; nhs++; wcnt = 0; end
      #1;
      cyc++;
    end
    in_valid = 1'b0; abort_i = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if ({in_ready, cen, set_out, busy, done} !== 5'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 00000", {in_ready, cen, set_out, busy, done});
    end
    n_cmp++; if (shift_out !== 2'b00) begin
      n_bad++; $display("FAIL reset_shift: got %b want 00", shift_out);
    end
    start = 1'b0; in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_release: ready=%b busy=%b want 0 0", in_ready, busy);
    end
  endtask

  task automatic test_basic_frame();
    logic [9:0] s0, s1; logic [3:0] pa;
    int ncen, nset, ndone, nhs, dc, viol, nwait;
    run_frame(0, 0, 0, 0, s0, s1, ncen, nset, ndone, nhs, dc, viol, nwait, pa);
    n_cmp++; if (s0 !== EXP0) begin n_bad++; $display("FAIL basic_chain0: got %b want %b", s0, EXP0); end
    n_cmp++; if (s1 !== EXP1) begin n_bad++; $display("FAIL basic_chain1: got %b want %b", s1, EXP1); end
    n_cmp++; if (ncen != 10) begin n_bad++; $display("FAIL basic_cen_count: got %0d want 10", ncen); end
    n_cmp++; if (nset != 2) begin n_bad++; $display("FAIL basic_set_cycles: got %0d want 2", nset); end
    n_cmp++; if (ndone != 1) begin n_bad++; $display("FAIL basic_done_count: got %0d want 1", ndone); end
    n_cmp++; if (nhs != 3) begin n_bad++; $display("FAIL basic_handshakes: got %0d want 3", nhs); end
    n_cmp++; if (dc != 16) begin n_bad++; $display("FAIL basic_done_cycle: got %0d want 16", dc); end
    n_cmp++; if (viol != 0) begin n_bad++; $display("FAIL basic_protocol: got %0d violations want 0", viol); end
  endtask

  task automatic test_backpressure();
    logic [9:0] s0, s1; logic [3:0] pa;
    int ncen, nset, ndone, nhs, dc, viol, nwait;
    run_frame(5, 0, 0, 0, s0, s1, ncen, nset, ndone, nhs, dc, viol, nwait, pa);
    n_cmp++; if (s0 !== EXP0 || s1 !== EXP1) begin
      n_bad++; $display("FAIL bp_stream: got %b/%b want %b/%b", s0, s1, EXP0, EXP1);
    end
    n_cmp++; if (nwait != 5) begin n_bad++; $display("FAIL bp_ready_wait: got %0d want 5", nwait); end
    n_cmp++; if (dc != 21) begin n_bad++; $display("FAIL bp_done_cycle: got %0d want 21", dc); end
    n_cmp++; if (viol != 0 || ncen != 10) begin
      n_bad++; $display("FAIL bp_protocol: viol=%0d cen=%0d want 0 10", viol, ncen);
    end
  endtask

  task automatic test_hold_valid();
    logic [9:0] s0, s1; logic [3:0] pa;
    int ncen, nset, ndone, nhs, dc, viol, nwait;
    run_frame(0, 1, 0, 0, s0, s1, ncen, nset, ndone, nhs, dc, viol, nwait, pa);
    n_cmp++; if (s0 !== EXP0 || s1 !== EXP1) begin
      n_bad++; $display("FAIL hold_stream: got %b/%b want %b/%b", s0, s1, EXP0, EXP1);
    end
    n_cmp++; if (nhs != 3 || dc != 16) begin
      n_bad++; $display("FAIL hold_timing: hs=%0d done_cyc=%0d want 3 16", nhs, dc);
    end
  endtask

  task automatic test_abort();
    logic [9:0] s0, s1; logic [3:0] pa;
    int ncen, nset, ndone, nhs, dc, viol, nwait;
    run_frame(0, 0, 1, 0, s0, s1, ncen, nset, ndone, nhs, dc, viol, nwait, pa);
    n_cmp++; if (pa !== 4'b0000) begin n_bad++; $display("FAIL abort_shift_next: got %b want 0000", pa); end
    n_cmp++; if (ncen != 3 || nset != 0 || ndone != 0) begin
      n_bad++; $display("FAIL abort_shift_counts: cen=%0d set=%0d done=%0d want 3 0 0", ncen, nset, ndone);
    end
    n_cmp++; if (s0[2:0] !== 3'b010 || s1[2:0] !== 3'b101) begin
      n_bad++; $display("FAIL abort_shift_bits: got %b/%b want 010/101", s0[2:0], s1[2:0]);
    end
    run_frame(0, 0, 0, 0, s0, s1, ncen, nset, ndone, nhs, dc, viol, nwait, pa);
    n_cmp++; if (s0 !== EXP0 || s1 !== EXP1 || dc != 16 || ndone != 1) begin
      n_bad++; $display("FAIL abort_rerun: got %b/%b done_cyc=%0d want %b/%b 16", s0, s1, dc, EXP0, EXP1);
    end
    run_frame(0, 0, 2, 0, s0, s1, ncen, nset, ndone, nhs, dc, viol, nwait, pa);
    n_cmp++; if (pa !== 4'b0000 || nset != 1 || ndone != 0) begin
      n_bad++; $display("FAIL abort_set: post=%b set=%0d done=%0d want 0000 1 0", pa, nset, ndone);
    end
  endtask

  task automatic test_start_races();
    logic [9:0] s0, s1; logic [3:0] pa;
    int ncen, nset, ndone, nhs, dc, viol, nwait;
    run_frame(0, 0, 0, 1, s0, s1, ncen, nset, ndone, nhs, dc, viol, nwait, pa);
    n_cmp++; if (s0 !== EXP0 || s1 !== EXP1 || dc != 16 || ndone != 1) begin
      n_bad++; $display("FAIL start_busy: got %b/%b done_cyc=%0d want %b/%b 16", s0, s1, dc, EXP0, EXP1);
    end
    start = 1'b1; abort_i = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort_i = 1'b0;
    n_cmp++; if (busy !== 1'b0 || in_ready !== 1'b0) begin
      n_bad++; $display("FAIL start_abort_idle: busy=%b ready=%b want 0 0", busy, in_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL start_abort_stay: busy=%b want 0", busy); end
  endtask

  task automatic test_async_reset();
    int guard;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_data = 8'h5A;
    guard = 0;
    while (!cen && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    n_cmp++; if (cen !== 1'b1) begin n_bad++; $display("FAIL async_reach_shift: cen=%b want 1", cen); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({in_ready, cen, shift_out, set_out, busy, done} !== 7'b0) begin
      n_bad++; $display("FAIL async_reset_outputs: got %b want 0000000",
                        {in_ready, cen, shift_out, set_out, busy, done});
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0 || set_out !== 1'b0) begin
      n_bad++; $display("FAIL async_release: busy=%b set=%b want 0 0", busy, set_out);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_hold_valid();
    test_abort();
    test_start_races();
    test_async_reset();
    test_basic_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end
endmodule
